// File: rtl/ser_add.sv
// rtl/ser_add.sv - bit-serial unsigned adder, LSB first
// Parallel load of a/b, then one registered sum bit per add clock; bit WIDTH is the carry-out.
module ser_add #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             sum
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH + 1);

  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sum_q, sum_d;

  always_comb begin
    ra_d  = ra_q;
    rb_d  = rb_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    if (mode) begin
      ra_d  = a;
      rb_d  = b;
      c_d   = 1'b0;
      cnt_d = '0;
      sum_d = 1'b0;
    end else begin
      sum_d = ra_q[0] ^ rb_q[0] ^ c_q;
      c_d   = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
      ra_d  = {1'b0, ra_q[WIDTH-1:1]};
      rb_d  = {1'b0, rb_q[WIDTH-1:1]};
      // Once drained, shift registers and carry are zero so the output stays 0.
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ra_q  <= '0;
      rb_q  <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      sum_q <= 1'b0;
    end else begin
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_ser_add.sv
// tb/tb_ser_add.sv - self-checking bench for ser_add
// Table-driven operand vectors with a scoreboard queue of expected serial bits.
module tb_ser_add;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sum;

  int errors;
  int checks;
  logic sb[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s;
  } vec_t;

  vec_t tbl[6];

  ser_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .sum   (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, queue its expected bit, then compare just after the edge.
  task automatic cycle(input logic r, input logic m, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic exp, input string name);
    logic e;
    reset = r;
    mode  = m;
    a     = av;
    b     = bv;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (sum !== e) begin
      errors++;
      $display("FAIL %s: sum=%b expected=%b", name, sum, e);
    end
  endtask

  task automatic load(input logic [W-1:0] av, input logic [W-1:0] bv, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, av, bv, 1'b0, "load");
  endtask

  // Stream n bits of s; a/b are scrambled to show they are ignored while adding.
  task automatic stream(input logic [W:0] s, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, W'($urandom), W'($urandom), (i <= W) ? s[i] : 1'b0, name);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    mode   = 1'b0;
    a      = '0;
    b      = '0;

    tbl[0] = '{16'h00FF, 16'h1111, 17'h01210};
    tbl[1] = '{16'hFFFF, 16'h0001, 17'h10000};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
    tbl[3] = '{16'h0003, 16'h0001, 17'h00004};
    tbl[4] = '{16'h1234, 16'h4321, 17'h05555};
    tbl[5] = '{16'h8000, 16'h8000, 17'h10000};

    // Reset and idle adding with no prior load
    cycle(1'b1, 1'b0, '0, '0, 1'b0, "reset");
    cycle(1'b1, 1'b0, '0, '0, 1'b0, "reset");
    stream('0, 20, "idle_after_reset");

    // Table vectors: double load, full stream, then drained zeros
    for (int t = 0; t < 6; t++) begin
      load(tbl[t].a, tbl[t].b, 2);
      stream(tbl[t].s, W + 4, $sformatf("vec%0d", t));
    end

    // Reload mid-stream: stale carry must be cleared
    load(16'h00FF, 16'h1111, 1);
    stream(17'h01210, 5, "pre_reload");
    cycle(1'b0, 1'b1, 16'h0003, 16'h0001, 1'b0, "reload_cycle");
    stream(17'h00004, W + 2, "post_reload");

    // Last of several differing loads wins
    load(16'hAAAA, 16'h5555, 1);
    load(16'h0F0F, 16'h0101, 1);
    stream(17'h01010, W + 1, "last_load_wins");

    // Reset mid-stream clears all state
    load(16'hFFFF, 16'h0001, 1);
    stream(17'h10000, 8, "pre_reset");
    cycle(1'b1, 1'b0, '0, '0, 1'b0, "mid_reset");
    stream('0, 20, "after_mid_reset");

    // Reset has priority over load
    cycle(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "reset_over_load");
    stream('0, 4, "after_reset_over_load");

    // Random operands checked against a reference addition
    for (int t = 0; t < 4; t++) begin
      logic [W-1:0] ra, rb;
      logic [W:0]   rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = {1'b0, ra} + {1'b0, rb};
      load(ra, rb, 1);
      stream(rs, W + 2, $sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_add.md
Name: ser_add

Overview:
- Bit-serial adder: parallel-loads two WIDTH-bit operands, then adds them one bit per clock, LSB first.
- Produces one registered sum bit per clock on a single-bit output.
- Used where a narrow serial result stream is wanted instead of a wide parallel adder. Unsigned arithmetic; the final carry-out is emitted as bit WIDTH.

Parameters:
- WIDTH, 16, operand width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mode  input  1  1 = parallel load of a/b; 0 = serial add/shift
- a  input  WIDTH  operand A, sampled only when mode=1
- b  input  WIDTH  operand B, sampled only when mode=1
- sum  output  1  registered serial sum bit, LSB first

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Internal state:
  - shift registers ra, rb (WIDTH bits each)
  - carry flip-flop c
  - bit counter cnt, 0..WIDTH+1, saturating
- Reset (reset=1 at posedge), priority over mode:
  - ra=0, rb=0, c=0, cnt=0, sum=0.
- Load (reset=0, mode=1 at posedge):
  - ra<=a, rb<=b, c<=0, cnt<=0, sum<=0.
  - Repeated load cycles simply reload. The last load wins.
- Add (reset=0, mode=0 at posedge):
  - sum <= ra[0]^rb[0]^c
  - c <= majority(ra[0], rb[0], c)
  - ra, rb shift right one position with 0 fill
  - cnt increments, saturating at WIDTH+1
- Latency:
  - Sum bit i (i=0..WIDTH-1) is visible on sum after the (i+1)th add edge following the last load.
  - After the (WIDTH+1)th add edge, sum = carry-out (bit WIDTH of a+b).
- After WIDTH+1 add cycles: registers are zero, so sum=0 on every further add cycle. The state is stable and needs no special handling.
- Arithmetic: full result is WIDTH+1 bits, a+b unsigned, streamed LSB first over WIDTH+1 cycles.
- mode dropping to 0 without a prior load (after reset): adds zeros, so sum=0.
- Load mid-stream (mode=1 while adding): aborts the current addition, restarts from the new operands, clears carry, drives sum=0 that cycle.
- Reset mid-operation: same as reset. State is cleared, and the next add cycles output 0 until a load occurs.
- a and b are ignored while mode=0. Changing them mid-stream has no effect.
- No X propagation: all state is reset-initialised.

Test Plan:
- Reset: reset=1 for 2 cycles → sum=0. Then mode=0 for 20 cycles → sum stays 0.
- Basic add, WIDTH=16: load a=0x00FF, b=0x1111 (mode=1 for 2 cycles, same operands), then mode=0 for 17 cycles.
  - sum stream LSB first = 0,0,0,0, 1,0,0,0, 0,1,0,0, 1,0,0,0, then 0 (carry-out) = 0x1210.
- Carry-out: load a=0xFFFF, b=0x0001, then 17 add cycles.
  - sum bits 0..15 all 0, bit 16 = 1. Subsequent add cycles → 0.
- Full carry chain: a=0xFFFF, b=0xFFFF.
  - Stream = 0, then fifteen 1s, then carry-out 1 (0x1FFFE).
- Reload mid-stream: load 0x00FF/0x1111, run 5 add cycles, then load a=0x0003, b=0x0001.
  - Load cycle gives sum=0. Next stream = 0,0,1,0,… (0x0004); no stale carry.
- Reset mid-stream: after 8 add cycles of 0xFFFF+0x0001, assert reset for 1 cycle.
  - sum=0 and stays 0 on subsequent add cycles.
  - Operand changes on a/b while mode=0 do not alter the stream.
